// File: rtl/led7_scan.sv
// led7_scan: time-multiplexed driver for a DIGITS-digit common-anode
// 7-segment display. A packed digit word and per-digit decimal points are
// latched on a load strobe. Digits are then scanned one slot at a time, and
// each slot begins with a short all-dark phase to suppress ghosting.
//
// Build option: define LED7_HEX_EN to show codes 10..15 as the hex glyphs
// A,b,C,d,E,F. When it is undefined, these codes blank the segments, but the
// anode and decimal point are still driven.
//
// Output polarity: all outputs are active-low (0 = lit / digit on).

module led7_scan #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   sw,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    output logic [6:0]            Do,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Segment pattern {a,b,c,d,e,f,g}, active-low.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
`ifdef LED7_HEX_EN
            4'd10:   seg = 7'b0001000;
            4'd11:   seg = 7'b1100000;
            4'd12:   seg = 7'b0110001;
            4'd13:   seg = 7'b1000010;
            4'd14:   seg = 7'b0110000;
            4'd15:   seg = 7'b0111000;
`endif
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // Shadow copy of the display word and decimal points.
    logic [4*DIGITS-1:0] val;
    logic [DIGITS-1:0]   dpv;

    // Scan position: cycle within slot and the active digit.
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    // Next-output values computed from the current scan position.
    logic [6:0]        seg_p0;
    logic              dpo_p0;
    logic [DIGITS-1:0] an_p0;
    logic [3:0]        code_p0;

    // Capture sw/dp on the load strobe. The scan position is not affected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= '0;
            dpv <= '0;
        end else if (load) begin
            val <= sw;
            dpv <= dp;
        end
    end

    // Slot counter. At the end of each slot, step to the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST)
                idx <= '0;
            else
                idx <= idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Stage p0: choose this cycle's glyph, anode and decimal point.
    always_comb begin
        code_p0 = val[4*idx +: 4];
        seg_p0  = SEG_OFF;
        dpo_p0  = 1'b1;
        an_p0   = '1;
        if (cnt >= CNT_BLANK) begin
            seg_p0 = decode(code_p0);
            dpo_p0 = ~dpv[idx];
            an_p0  = ~(DIGITS'(1) << idx);
        end
    end

    // Stage p1: register the outputs so that no input reaches a pin combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Do   <= SEG_OFF;
            dp_o <= 1'b1;
            an   <= '1;
        end else begin
            Do   <= seg_p0;
            dp_o <= dpo_p0;
            an   <= an_p0;
        end
    end

endmodule

// File: tb/tb_led7_scan.sv
// Bench for led7_scan with DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
// A cycle-count model predicts {an, Do, dp_o} as each clock edge is driven.
// Each prediction is queued, then popped and compared once the DUT has
// registered that edge.

module tb_led7_scan;

    localparam int DIGITS = 4;
    localparam int RDIV   = 4;
    localparam int BLANK  = 1;

    logic                 clk;
    logic                 rst_n;
    logic [4*DIGITS-1:0]  sw;
    logic [DIGITS-1:0]    dp;
    logic                 load;
    logic [6:0]           Do;
    logic                 dp_o;
    logic [DIGITS-1:0]    an;

    led7_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RDIV),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .dp   (dp),
        .load (load),
        .Do   (Do),
        .dp_o (dp_o),
        .an   (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expected {an[3:0], Do[6:0], dp_o}.
    logic [11:0] sb[$];

    // Model state: edges since reset release, shadow value and dp.
    int          mk;
    logic [15:0] mval;
    logic [3:0]  mdpv;
    logic [6:0]  glyph [16];

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got an=%b Do=%b dp_o=%b, expected an=%b Do=%b dp_o=%b",
                     tag, $time, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Output the DUT registers on the coming edge, from the model state before it.
    function automatic logic [11:0] model_out();
        int         phase;
        int         digit;
        logic [3:0] onehot;
        logic [3:0] nib;
        phase = mk % RDIV;
        digit = (mk / RDIV) % DIGITS;
        if (phase < BLANK)
            return {4'hF, 7'h7F, 1'b1};
        onehot = 4'b0001 << digit;
        nib    = mval[4*digit +: 4];
        return {~onehot, glyph[nib], ~mdpv[digit]};
    endfunction

    // One clock: predict, advance the model, then compare on the falling edge.
    task automatic tick(input string tag);
        logic [11:0] e;
        sb.push_back(model_out());
        if (load) begin
            mval = sw;
            mdpv = dp;
        end
        mk++;
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check(tag, {an, Do, dp_o}, e);
        load = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic do_load(input string tag, input logic [15:0] v, input logic [3:0] d);
        sw   = v;
        dp   = d;
        load = 1'b1;
        tick(tag);
    endtask

    // Assert reset between edges, check the outputs go dark immediately, then release on a falling edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check(tag, {an, Do, dp_o}, {4'hF, 7'h7F, 1'b1});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        mk   = 0;
        mval = '0;
        mdpv = '0;
    endtask

    initial begin
        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111;
        glyph[2]  = 7'b0010010; glyph[3]  = 7'b0000110;
        glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0000100;
`ifdef LED7_HEX_EN
        glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010;
        glyph[14] = 7'b0110000; glyph[15] = 7'b0111000;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 7'b1111111;
`endif

        rst_n = 1'b1;
        load  = 1'b0;
        sw    = '0;
        dp    = '0;
        mk    = 0;
        mval  = '0;
        mdpv  = '0;

        // Reset is asserted between edges, before any load.
        @(posedge clk);
        async_reset("reset_async");
        tick("reset_blank");
        run("reset_idle", 7);

        // Digits 1234, no decimal points: two full frames.
        do_load("load_1234", 16'h1234, 4'b0000);
        run("scan_1234", 32);

        // Code 10 on digit 1, with the decimal point on digit 2.
        do_load("load_00a0", 16'h00A0, 4'b0100);
        run("scan_00a0", 16);

        // Decimal point on digit 2 only, across blank and lit phases.
        do_load("load_dp", 16'h1234, 4'b0100);
        run("scan_dp", 16);

        // Load mid-slot, during digit 0's second lit cycle.
        while (mk % 16 != 2) tick("align_mid");
        do_load("load_mid", 16'h9999, 4'b0000);
        run("scan_9999", 16);

        // Load landing exactly on a slot boundary.
        while (mk % RDIV != RDIV - 1) tick("align_bnd");
        do_load("load_bnd", 16'h5678, 4'b1001);
        run("scan_5678", 16);

        // Reset during digit 2's lit phase: the scan resumes at digit 0, with the value cleared.
        while (mk % 16 != 10) tick("align_rst");
        async_reset("reset_mid");
        run("after_rst", 16);

        // Random loads, including hex codes and random decimal points.
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                sw   = 16'($urandom);
                dp   = 4'($urandom);
                load = 1'b1;
            end
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog: stop the run if it overruns.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected the run to finish");
        $fatal(1, "timeout");
    end

endmodule
